// File: rtl/pe_fetch_ctrl.sv
// pe_fetch_ctrl: walks the instruction memory (one iteration count per entry)
// and streams that many neuron/weight beats to parallel_pe.
//
// Handshake: there is no backpressure from the PE. A beat is requested from
// the SRAMs with mem_rd_en; the read data returns one cycle later, and
// pe_vld/pe_ctl are registered so they line up with that returning data.
// stall in RUN suppresses both the read and the beat that would follow it.
module pe_fetch_ctrl #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 16,
    parameter int INST_AW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [INST_AW:0]    inst_num,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic                inst_rd_en,
    output logic [INST_AW-1:0]  inst_addr,
    input  logic [7:0]          inst_rdata,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   neuron_addr,
    output logic [ADDR_W-1:0]   weight_addr,
    input  logic [DATA_W-1:0]   neuron_rdata,
    input  logic [DATA_W-1:0]   weight_rdata,
    output logic [DATA_W-1:0]   pe_neuron,
    output logic [DATA_W-1:0]   pe_weight,
    output logic [1:0]          pe_ctl,
    output logic                pe_vld,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [INST_AW:0]   inst_ptr;
    logic [INST_AW:0]   inst_num_q;
    logic [INST_AW:0]   ptr_inc;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         count;
    logic [7:0]         iter;
    logic               more_inst;
    logic               issue;
    logic               last_beat;

    assign ptr_inc   = inst_ptr + 1'b1;
    // Another instruction remains once the current one retires.
    assign more_inst = (ptr_inc < inst_num_q);
    assign issue     = (state == S_RUN) && !stall;
    assign last_beat = (iter == (count - 8'd1));

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign inst_addr   = inst_ptr[INST_AW-1:0];
    assign neuron_addr = addr;
    assign weight_addr = addr;
    assign pe_neuron   = neuron_rdata;
    assign pe_weight   = weight_rdata;
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and the combinational read strobes.
    always_comb begin
        state_nxt  = state;
        inst_rd_en = 1'b0;
        mem_rd_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (inst_num != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                inst_rd_en = 1'b1;
                state_nxt  = S_LATCH;
            end
            S_LATCH: begin
                if (inst_rdata == 8'd0) state_nxt = more_inst ? S_FETCH : S_DONE;
                else                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    mem_rd_en = 1'b1;
                    if (last_beat) state_nxt = more_inst ? S_FETCH : S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Program pointers, iteration counters and the registered PE strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_ptr   <= '0;
            inst_num_q <= '0;
            addr       <= '0;
            count      <= '0;
            iter       <= '0;
            pe_vld     <= 1'b0;
            pe_ctl     <= 2'b00;
        end else begin
            pe_vld <= issue;
            if (issue) pe_ctl <= {last_beat, (iter == 8'd0)};
            case (state)
                S_IDLE: begin
                    if (start && (inst_num != '0)) begin
                        inst_ptr   <= '0;
                        addr       <= '0;
                        iter       <= '0;
                        inst_num_q <= inst_num;
                    end
                end
                S_LATCH: begin
                    count <= inst_rdata;
                    iter  <= '0;
                    // A zero-count instruction retires without producing beats.
                    if (inst_rdata == 8'd0) inst_ptr <= ptr_inc;
                end
                S_RUN: begin
                    if (!stall) begin
                        // Address wraps silently at the top of the SRAM.
                        addr <= addr + 1'b1;
                        iter <= iter + 8'd1;
                        if (last_beat) inst_ptr <= ptr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_fetch_ctrl.sv
// Bench for pe_fetch_ctrl: instruction/data SRAM models, a program-level
// reference that expands instruction counts into the expected beat list,
// and a monitor that scores every beat the DUT emits.
module tb_pe_fetch_ctrl;

    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 16;
    localparam int INST_AW = 2;
    localparam logic [31:0] SALT_N = 32'h1357_9bdf;
    localparam logic [31:0] SALT_W = 32'h2468_ace1;

    logic                clk;
    logic                rst;
    logic                start;
    logic [INST_AW:0]    inst_num;
    logic                stall;
    logic                busy;
    logic                done;
    logic                inst_rd_en;
    logic [INST_AW-1:0]  inst_addr;
    logic [7:0]          inst_rdata;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   neuron_addr;
    logic [ADDR_W-1:0]   weight_addr;
    logic [DATA_W-1:0]   neuron_rdata;
    logic [DATA_W-1:0]   weight_rdata;
    logic [DATA_W-1:0]   pe_neuron;
    logic [DATA_W-1:0]   pe_weight;
    logic [1:0]          pe_ctl;
    logic                pe_vld;
    logic [2:0]          dbg_state;

    // Expected beat: {address, ctl}
    logic [17:0] exp_q[$];
    logic [7:0]  imem[4];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int exp_beats = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int stall_mode = 0;
    int stall_left = 0;
    bit exp_done_beat = 0;
    logic prev_rd = 1'b0;

    pe_fetch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INST_AW(INST_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .inst_num(inst_num), .stall(stall),
        .busy(busy), .done(done), .inst_rd_en(inst_rd_en), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .mem_rd_en(mem_rd_en), .neuron_addr(neuron_addr),
        .weight_addr(weight_addr), .neuron_rdata(neuron_rdata),
        .weight_rdata(weight_rdata), .pe_neuron(pe_neuron), .pe_weight(pe_weight),
        .pe_ctl(pe_ctl), .pe_vld(pe_vld), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Deterministic data content per address, different for neuron/weight.
    function automatic logic [DATA_W-1:0] gen_d(input logic [15:0] a, input logic [31:0] salt);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = {a, ~a} ^ (salt * (i + 1));
        return r;
    endfunction

    // SRAM models with one cycle read latency
    always @(posedge clk) begin
        if (inst_rd_en) inst_rdata <= imem[inst_addr];
        if (mem_rd_en) begin
            neuron_rdata <= gen_d(neuron_addr, SALT_N);
            weight_rdata <= gen_d(weight_addr, SALT_W);
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stall driver: off, random, or a scripted 2-cycle stall after the 2nd read
    initial begin
        stall = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (stall_mode)
                1: stall = ($urandom_range(0, 3) == 0);
                2: begin
                    if (rd_cnt == 2 && stall_left > 0) begin
                        stall = 1'b1;
                        stall_left--;
                    end else begin
                        stall = 1'b0;
                    end
                end
                default: stall = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_rd = 1'b0;
            end else begin
                chk("vld_align", pe_vld, prev_rd);
                if (mem_rd_en) begin
                    rd_cnt++;
                    chk("addr_equal", weight_addr, neuron_addr);
                    chk("rd_while_stall", stall, 1'b0);
                end
                if (pe_vld) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: ctl %b with empty expected queue", pe_ctl);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pe_ctl", pe_ctl, e[1:0]);
                        chk("pe_neuron", pe_neuron, gen_d(e[17:2], SALT_N));
                        chk("pe_weight", pe_weight, gen_d(e[17:2], SALT_W));
                    end
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_all_beats", exp_q.size(), 0);
                    if (exp_done_beat) chk("done_with_last", {pe_vld, pe_ctl[1]}, 2'b11);
                end
                prev_rd = mem_rd_en;
            end
        end
    end

    // Expand the program into expected beats and issue start.
    task automatic launch(input int n, input bit chk_lat);
        int a = 0;
        int lat;
        done_cnt  = 0;
        rd_cnt    = 0;
        first_cyc = -1;
        last_cyc  = -1;
        exp_done_beat = (n > 0) && (imem[n-1] != 8'd0);
        for (int i = 0; i < n; i++) begin
            int c = imem[i];
            for (int k = 0; k < c; k++) begin
                exp_q.push_back({a[15:0], (k == c - 1), (k == 0)});
                a++;
            end
        end
        exp_beats = a;
        @(negedge clk);
        start = 1'b1;
        inst_num = n[INST_AW:0];
        @(negedge clk);
        start = 1'b0;
        if (n == 0) chk("done_zero_prog", done, 1'b1);
        if (chk_lat) begin
            lat = 0;
            while (!pe_vld && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", lat, 3);
        end
    endtask

    task automatic finish_prog(input int span_exp);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", (done_cnt != 0), 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_after", busy, 1'b0);
        chk("done_count", done_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("read_count", rd_cnt, exp_beats);
        if (span_exp >= 0) chk("beat_span", last_cyc - first_cyc + 1, span_exp);
    endtask

    task automatic set_imem(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        imem[0] = c0; imem[1] = c1; imem[2] = c2; imem[3] = c3;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        inst_num = '0;
        set_imem(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, inst_rd_en, mem_rd_en, pe_vld, pe_ctl,
                           inst_addr, neuron_addr, weight_addr}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Single instruction, count 3
        set_imem(8'd3, 8'd0, 8'd0, 8'd0);
        launch(1, 1'b1);
        finish_prog(3);

        // Full program: 4 x 35 beats, 2 bubbles between instructions
        set_imem(8'd35, 8'd35, 8'd35, 8'd35);
        launch(4, 1'b1);
        finish_prog(146);

        // Scripted stall of 2 cycles after the 2nd read
        set_imem(8'd4, 8'd0, 8'd0, 8'd0);
        stall_mode = 2;
        stall_left = 2;
        launch(1, 1'b1);
        finish_prog(6);
        stall_mode = 0;

        // Boundary counts 0, 1, 2
        set_imem(8'd0, 8'd1, 8'd2, 8'd0);
        launch(3, 1'b0);
        finish_prog(5);

        // start pulsed mid-RUN must be ignored
        set_imem(8'd10, 8'd10, 8'd10, 8'd10);
        launch(4, 1'b0);
        repeat (8) @(negedge clk);
        start = 1'b1;
        inst_num = 3'd1;
        @(negedge clk);
        start = 1'b0;
        finish_prog(46);

        // Empty program
        launch(0, 1'b0);
        finish_prog(-1);

        // Randomized programs with random stall
        stall_mode = 1;
        for (int r = 0; r < 20; r++) begin
            set_imem($urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 12), $urandom_range(0, 12));
            launch($urandom_range(0, 4), 1'b0);
            finish_prog(-1);
        end
        stall_mode = 0;
        repeat (2) @(negedge clk);

        // Reset mid-run, then replay from address 0
        set_imem(8'd35, 8'd35, 8'd35, 8'd35);
        launch(4, 1'b0);
        repeat (30) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("reset_async", {busy, done, inst_rd_en, mem_rd_en, pe_vld, pe_ctl,
                               inst_addr, neuron_addr, weight_addr}, '0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", busy, 1'b0);
        launch(4, 1'b1);
        finish_prog(146);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
